// File: rtl/hilo_pkg.sv
// Shared HI/LO constants: word/pair widths (same as the MDU's), half indices, read FSM encoding.
package hilo_pkg;

  localparam int WORD_W = 32;
  localparam int PAIR_W = 2 * WORD_W;

  localparam int HI_BIT = 1;
  localparam int LO_BIT = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  function automatic logic [WORD_W-1:0] pick_word(input logic [PAIR_W-1:0] pair, input logic sel_hi);
    return sel_hi ? pair[PAIR_W-1:WORD_W] : pair[WORD_W-1:0];
  endfunction

endpackage

// File: rtl/hilo_read_fsm.sv
// MFHI/MFLO read sequencer (IDLE/WAIT/RESP): decides accept, captures the selected word, pulses rd_valid.
// Captures from the post-write pair, so a read accepted alongside a write returns the written half.
module hilo_read_fsm
  import hilo_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic              rd_sel,
  input  logic              cancel,
  input  logic              busy,
  input  logic              mdu_data_ok,
  input  logic              wr_accept_ok,
  input  logic [PAIR_W-1:0] hilo_nxt,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [WORD_W-1:0] rd_data
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       can_accept;
  logic       req_state;

  assign can_accept = mdu_data_ok ? wr_accept_ok : !busy;
  assign req_state  = (state == ST_IDLE) || (state == ST_WAIT);
  assign rd_ready   = rst && !cancel && req_state && rd_req && can_accept;
  assign rd_valid   = rst && !cancel && (state == ST_RESP);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (rd_req) state_nxt = rd_ready ? ST_RESP : ST_WAIT;
      ST_WAIT: begin
        if (!rd_req)       state_nxt = ST_IDLE;
        else if (rd_ready) state_nxt = ST_RESP;
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (cancel) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      rd_data <= '0;
    end else begin
      state <= state_nxt;
      if (rd_ready) rd_data <= pick_word(hilo_nxt, rd_sel);
    end
  end

endmodule

// File: rtl/hilo_regfile.sv
// HI/LO register pair with MDU write port, in-flight busy tracking and a handshaked MFHI/MFLO read port.
// Define HILO_BYPASS_EN to allow read accept in the same cycle as the MDU write that clears busy.
module hilo_regfile
  import hilo_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              mdu_issue,
  input  logic              mdu_data_ok,
  input  logic [1:0]        mdu_we,
  input  logic [PAIR_W-1:0] mdu_wdata,
  input  logic              cancel,
  output logic [PAIR_W-1:0] hilo_data,
  output logic              hilo_busy,
  input  logic              rd_req,
  input  logic              rd_sel,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [WORD_W-1:0] rd_data
);

  logic [PAIR_W-1:0] hilo;
  logic [PAIR_W-1:0] hilo_nxt;
  logic              busy;
  logic              busy_nxt;
  logic              wr_accept_ok;

  always_comb begin
    hilo_nxt = hilo;
    if (mdu_data_ok && mdu_we[HI_BIT]) hilo_nxt[PAIR_W-1:WORD_W] = mdu_wdata[PAIR_W-1:WORD_W];
    if (mdu_data_ok && mdu_we[LO_BIT]) hilo_nxt[WORD_W-1:0]      = mdu_wdata[WORD_W-1:0];
  end

  // A cancelled cycle still commits its write: data_ok is already qualified upstream.
  assign busy_nxt = cancel ? 1'b0 : (busy ^ (mdu_issue ^ mdu_data_ok));

  always_ff @(posedge clk) begin
    if (!rst) begin
      hilo <= '0;
      busy <= 1'b0;
    end else begin
      hilo <= hilo_nxt;
      busy <= busy_nxt;
    end
  end

  assign hilo_data = hilo;
  assign hilo_busy = busy;

`ifdef HILO_BYPASS_EN
  assign wr_accept_ok = !busy_nxt;
`else
  assign wr_accept_ok = 1'b0;
`endif

  hilo_read_fsm u_read_fsm (
    .clk          (clk),
    .rst          (rst),
    .rd_req       (rd_req),
    .rd_sel       (rd_sel),
    .cancel       (cancel),
    .busy         (busy),
    .mdu_data_ok  (mdu_data_ok),
    .wr_accept_ok (wr_accept_ok),
    .hilo_nxt     (hilo_nxt),
    .rd_ready     (rd_ready),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data)
  );

endmodule

// File: tb/tb_hilo_regfile.sv
// Bench for hilo_regfile: directed scenarios plus randomized traffic against an outstanding-count model.
module tb_hilo_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mdu_issue, mdu_data_ok, cancel, rd_req, rd_sel;
  logic [1:0]  mdu_we;
  logic [63:0] mdu_wdata;
  logic [63:0] hilo_data;
  logic        hilo_busy, rd_ready, rd_valid;
  logic [31:0] rd_data;

  int errors = 0;
  int checks = 0;

  hilo_regfile dut (
    .clk(clk), .rst(rst), .mdu_issue(mdu_issue), .mdu_data_ok(mdu_data_ok),
    .mdu_we(mdu_we), .mdu_wdata(mdu_wdata), .cancel(cancel),
    .hilo_data(hilo_data), .hilo_busy(hilo_busy), .rd_req(rd_req), .rd_sel(rd_sel),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic iss, input logic ok, input logic [1:0] we, input logic [63:0] wd,
                       input logic cn, input logic rq, input logic sl);
    mdu_issue = iss; mdu_data_ok = ok; mdu_we = we; mdu_wdata = wd;
    cancel = cn; rd_req = rq; rd_sel = sl;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 2'b00, 64'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic advance();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; idle_in();
    advance();
    drive(1'b0, 1'b0, 2'b00, 64'h0, 1'b0, 1'b1, 1'b1);
    advance();
    @(negedge clk);
    checks++; if (hilo_data !== 64'h0) begin errors++; $display("FAIL reset_hilo got=%h exp=0", hilo_data); end
    checks++; if (hilo_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", hilo_busy); end
    checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", rd_ready); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rd_valid); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rd_data); end
    rst = 1'b1; #1;
    checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL idle_read_ready got=%b exp=1", rd_ready); end
    advance(); idle_in();
    @(negedge clk);
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL idle_read_valid got=%b exp=1", rd_valid); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL idle_read_data got=%h exp=0", rd_data); end
    advance();
    @(negedge clk);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL idle_read_pulse got=%b exp=0", rd_valid); end
  endtask

  task automatic test_mt_write();
    drive(1'b1, 1'b1, 2'b01, {32'h1234_5678, 32'h1234_5678}, 1'b0, 1'b0, 1'b0);
    advance(); idle_in();
    @(negedge clk);
    checks++; if (hilo_data !== 64'h0000_0000_1234_5678) begin errors++; $display("FAIL mt_hilo got=%h exp=0000000012345678", hilo_data); end
    checks++; if (hilo_busy !== 1'b0) begin errors++; $display("FAIL mt_busy got=%b exp=0", hilo_busy); end
    drive(1'b0, 1'b0, 2'b00, 64'h0, 1'b0, 1'b1, 1'b0);
    advance(); idle_in();
    @(negedge clk);
    checks++; if (rd_valid !== 1'b1 || rd_data !== 32'h1234_5678) begin errors++; $display("FAIL mflo_after_mt got=%b/%h exp=1/12345678", rd_valid, rd_data); end
    advance();
  endtask

  task automatic test_mul_inflight();
    drive(1'b1, 1'b0, 2'b00, 64'h0, 1'b0, 1'b0, 1'b0);
    advance();
    drive(1'b0, 1'b0, 2'b00, 64'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (hilo_busy !== 1'b1) begin errors++; $display("FAIL mul_busy got=%b exp=1", hilo_busy); end
    checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL mul_wait_c1 got=%b exp=0", rd_ready); end
    advance();
    for (int c = 2; c < 5; c++) begin
      @(negedge clk);
      checks++; if (rd_ready !== 1'b0 || rd_valid !== 1'b0) begin errors++; $display("FAIL mul_wait_c%0d ready/valid got=%b/%b exp=0/0", c, rd_ready, rd_valid); end
      advance();
    end
    drive(1'b0, 1'b1, 2'b11, 64'h0000_0002_FFFF_FFFE, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (hilo_data !== 64'h0000_0000_1234_5678) begin errors++; $display("FAIL mul_no_forward got=%h exp=0000000012345678", hilo_data); end
`ifdef HILO_BYPASS_EN
    checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL mul_accept_c5 got=%b exp=1", rd_ready); end
    advance(); idle_in();
`else
    checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL mul_accept_c5 got=%b exp=0", rd_ready); end
    advance();
    drive(1'b0, 1'b0, 2'b00, 64'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (rd_ready !== 1'b1 || hilo_busy !== 1'b0) begin errors++; $display("FAIL mul_accept_c6 ready/busy got=%b/%b exp=1/0", rd_ready, hilo_busy); end
    advance(); idle_in();
`endif
    @(negedge clk);
    checks++; if (rd_valid !== 1'b1 || rd_data !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mul_result got=%b/%h exp=1/fffffffe", rd_valid, rd_data); end
    checks++; if (hilo_data !== 64'h0000_0002_FFFF_FFFE) begin errors++; $display("FAIL mul_hilo got=%h exp=00000002fffffffe", hilo_data); end
    advance();
  endtask

  task automatic test_cancel();
    drive(1'b1, 1'b0, 2'b00, 64'h0, 1'b0, 1'b0, 1'b0);
    advance();
    drive(1'b0, 1'b0, 2'b00, 64'h0, 1'b0, 1'b1, 1'b1);
    advance();
    drive(1'b0, 1'b0, 2'b00, 64'h0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (rd_ready !== 1'b0 || rd_valid !== 1'b0) begin errors++; $display("FAIL cancel_cycle ready/valid got=%b/%b exp=0/0", rd_ready, rd_valid); end
    advance(); idle_in();
    @(negedge clk);
    checks++; if (hilo_busy !== 1'b0) begin errors++; $display("FAIL cancel_busy got=%b exp=0", hilo_busy); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL cancel_no_valid got=%b exp=0", rd_valid); end
    advance();
    drive(1'b0, 1'b0, 2'b00, 64'h0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL cancel_then_idle got=%b exp=1", rd_ready); end
    advance(); idle_in();
    @(negedge clk);
    checks++; if (rd_valid !== 1'b1 || rd_data !== 32'h2) begin errors++; $display("FAIL cancel_old_value got=%b/%h exp=1/00000002", rd_valid, rd_data); end
    advance();
    drive(1'b0, 1'b0, 2'b00, 64'h0, 1'b0, 1'b1, 1'b0);
    advance();
    drive(1'b0, 1'b0, 2'b00, 64'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL cancel_in_resp got=%b exp=0", rd_valid); end
    advance(); idle_in();
    @(negedge clk);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL cancel_resp_after got=%b exp=0", rd_valid); end
    advance();
  endtask

  task automatic test_partial_write();
    drive(1'b1, 1'b1, 2'b11, {32'hAAAA_0000, 32'h0000_5555}, 1'b0, 1'b0, 1'b0);
    advance();
    drive(1'b1, 1'b1, 2'b10, {32'hDEAD_BEEF, 32'h0}, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (hilo_data !== 64'hAAAA_0000_0000_5555) begin errors++; $display("FAIL partial_setup got=%h exp=aaaa000000005555", hilo_data); end
    advance(); idle_in();
    @(negedge clk);
    checks++; if (hilo_data !== 64'hDEAD_BEEF_0000_5555) begin errors++; $display("FAIL partial_hi_only got=%h exp=deadbeef00005555", hilo_data); end
    drive(1'b1, 1'b1, 2'b00, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
    advance(); idle_in();
    @(negedge clk);
    checks++; if (hilo_data !== 64'hDEAD_BEEF_0000_5555) begin errors++; $display("FAIL we00_noop got=%h exp=deadbeef00005555", hilo_data); end
    advance();
  endtask

  task automatic test_back_to_back();
    int nrdy = 0;
    int nval = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 2'b00, 64'h0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      nrdy += int'(rd_ready); nval += int'(rd_valid);
      checks++; if (rd_ready !== ((i % 2) == 0) || rd_valid !== ((i % 2) == 1)) begin errors++; $display("FAIL b2b_c%0d ready/valid got=%b/%b exp=%b/%b", i, rd_ready, rd_valid, (i % 2) == 0, (i % 2) == 1); end
      if (rd_valid === 1'b1) begin
        checks++; if (rd_data !== 32'h0000_5555) begin errors++; $display("FAIL b2b_data_c%0d got=%h exp=00005555", i, rd_data); end
      end
      advance();
    end
    idle_in();
    checks++; if (nrdy != 2 || nval != 2) begin errors++; $display("FAIL b2b_counts accepts/valids got=%0d/%0d exp=2/2", nrdy, nval); end
    advance();
  endtask

  // Model: outstanding-op count, pending-response flag and captured word; no notion of FSM states.
  task automatic test_random();
    logic [31:0] m_hi = 0, m_lo = 0, m_cap = 0, wd_word;
    int          m_out = 0;
    bit          m_resp = 0, req_on = 0, req_sel = 0;
    bit          iss, ok, cn, ok_cond, e_ready, e_valid;
    logic [1:0]  we;
    logic [63:0] wd;
    rst = 1'b0; idle_in();
    advance(); advance();
    rst = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      iss = 0; ok = 0; we = 2'b00; wd = {$urandom, $urandom};
      cn = ($urandom_range(0, 15) == 0);
      if (m_out > 0) begin
        if ($urandom_range(0, 3) == 0) begin ok = 1; we = 2'($urandom_range(0, 3)); end
      end else begin
        case ($urandom_range(0, 7))
          0, 1: iss = 1;
          2: begin iss = 1; ok = 1; we = 2'($urandom_range(0, 3)); end
          default: ;
        endcase
      end
      if (!req_on && $urandom_range(0, 2) == 0) begin req_on = 1; req_sel = $urandom_range(0, 1) != 0; end
      drive(iss, ok, we, wd, cn, req_on, req_sel);
`ifdef HILO_BYPASS_EN
      ok_cond = ok ? (m_out + int'(iss) - int'(ok) == 0) : (m_out == 0);
`else
      ok_cond = !ok && (m_out == 0);
`endif
      e_ready = req_on && !m_resp && !cn && ok_cond;
      e_valid = m_resp && !cn;
      @(negedge clk);
      checks++; if (rd_ready !== e_ready) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, rd_ready, e_ready); end
      checks++; if (rd_valid !== e_valid) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, rd_valid, e_valid); end
      if (e_valid) begin
        checks++; if (rd_data !== m_cap) begin errors++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, rd_data, m_cap); end
      end
      checks++; if (hilo_data !== {m_hi, m_lo}) begin errors++; $display("FAIL rnd_hilo cyc=%0d got=%h exp=%h", cyc, hilo_data, {m_hi, m_lo}); end
      checks++; if (hilo_busy !== (m_out != 0)) begin errors++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, hilo_busy, m_out != 0); end
      if (e_ready) begin
        wd_word = req_sel ? wd[63:32] : wd[31:0];
        m_cap = (ok && we[req_sel ? 1 : 0]) ? wd_word : (req_sel ? m_hi : m_lo);
      end
      if (ok && we[1]) m_hi = wd[63:32];
      if (ok && we[0]) m_lo = wd[31:0];
      m_out  = cn ? 0 : m_out + int'(iss) - int'(ok);
      m_resp = e_ready;
      if (e_ready || cn) req_on = 0;
      advance();
    end
    idle_in();
  endtask

  initial begin
    idle_in();
    test_reset();
    test_mt_write();
    test_mul_inflight();
    test_cancel();
    test_partial_write();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
